// File: rtl/cpu_types_pkg.sv
// Shared CPU types: default datapath sizes, register index and data word types.
package cpu_types_pkg;

   localparam int unsigned DefaultDw   = 32;
   localparam int unsigned DefaultNreg = 32;

   typedef logic [$clog2(DefaultNreg)-1:0] regidx_t;
   typedef logic [DefaultDw-1:0]           word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reservations,
// cleared by writes; a same-cycle set on the cleared index wins.
module reg_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            set_en,
   input  logic [AW-1:0]   set_sel,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_sel,
   output logic [NREG-1:0] busy_vec
);

   logic [NREG-1:0] busy_d, busy_q;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_sel] = 1'b0;
      if (set_en) busy_d[set_sel] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Flop-based register file with hardwired-zero r0, optional write-to-read
// forwarding and an integrated busy scoreboard for operand hazards.
module regfile_scoreboard
   import cpu_types_pkg::*;
#(
   parameter int unsigned DW     = DefaultDw,
   parameter int unsigned NREG   = DefaultNreg,
   parameter int unsigned NRD    = 2,
   parameter bit          BYPASS = 1'b1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WEN,
   input  logic [AW-1:0]     wsel,
   input  logic [DW-1:0]     wdat,
   input  logic [NRD*AW-1:0] rsel,
   output logic [NRD*DW-1:0] rdat,
   input  logic              RSV,
   input  logic [AW-1:0]     rsv_sel,
   output logic [NRD-1:0]    rd_busy,
   output logic [NREG-1:0]   busy_vec
);

   logic [DW-1:0] regs_q [NREG];
   logic [AW-1:0] rsel_a [NRD];
   logic          wr_en;
   logic          rsv_en;

   assign wr_en  = WEN && (wsel != '0);
   assign rsv_en = RSV && (rsv_sel != '0);

   // Entry 0 is only ever cleared, so it stays zero after the first reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wsel] <= wdat;
      end
   end

   reg_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .CLK      (CLK),
      .RST      (RST),
      .set_en   (rsv_en),
      .set_sel  (rsv_sel),
      .clr_en   (wr_en),
      .clr_sel  (wsel),
      .busy_vec (busy_vec)
   );

   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rsel_a[i] = rsel[i*AW +: AW];
      end
   end

   // Forwarding also hides the hazard: the pending value is on wdat right now.
   always_comb begin
      rdat    = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rsel_a[i] != '0) begin
            if (BYPASS && WEN && (wsel == rsel_a[i])) begin
               rdat[i*DW +: DW] = wdat;
               rd_busy[i]       = 1'b0;
            end else begin
               rdat[i*DW +: DW] = regs_q[rsel_a[i]];
               rd_busy[i]       = busy_vec[rsel_a[i]];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table plus random traffic,
// run on a forwarding 2-port build and a non-forwarding 4-port build.
module tb_regfile_scoreboard;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        RST, WEN, RSV;
   regidx_t     wsel, rsv_sel;
   word_t       wdat;
   logic [9:0]  rsel_a;
   logic [19:0] rsel_b;
   logic [63:0]  rdat_a;
   logic [127:0] rdat_b;
   logic [1:0]  rb_a;
   logic [3:0]  rb_b;
   logic [31:0] bv_a, bv_b;

   int checks = 0;
   int errors = 0;

   // Reference state: architectural register values and pending flags.
   word_t mdl_regs [32];
   bit    mdl_busy [32];

   regfile_scoreboard u_dut_a (
      .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel(rsel_a), .rdat(rdat_a),
      .RSV(RSV), .rsv_sel(rsv_sel), .rd_busy(rb_a), .busy_vec(bv_a)
   );

   regfile_scoreboard #(.NRD(4), .BYPASS(1'b0)) u_dut_b (
      .CLK(CLK), .RST(RST), .WEN(WEN), .wsel(wsel), .wdat(wdat), .rsel(rsel_b), .rdat(rdat_b),
      .RSV(RSV), .rsv_sel(rsv_sel), .rd_busy(rb_b), .busy_vec(bv_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic word_t mdl_rd(input regidx_t sel, input bit byp);
      if (sel == 0) return '0;
      if (byp && WEN && wsel == sel) return wdat;
      return mdl_regs[sel];
   endfunction

   function automatic logic mdl_rb(input regidx_t sel, input bit byp);
      if (sel == 0) return 1'b0;
      if (byp && WEN && wsel == sel) return 1'b0;
      return mdl_busy[sel];
   endfunction

   function automatic logic [31:0] mdl_bv();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = mdl_busy[r];
      return v;
   endfunction

   task automatic check_model();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("A rdat%0d", i), rdat_a[i*32 +: 32], mdl_rd(rsel_a[i*5 +: 5], 1'b1));
         chk($sformatf("A rd_busy%0d", i), 32'(rb_a[i]), 32'(mdl_rb(rsel_a[i*5 +: 5], 1'b1)));
      end
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("B rdat%0d", i), rdat_b[i*32 +: 32], mdl_rd(rsel_b[i*5 +: 5], 1'b0));
         chk($sformatf("B rd_busy%0d", i), 32'(rb_b[i]), 32'(mdl_rb(rsel_b[i*5 +: 5], 1'b0)));
      end
      chk("A busy_vec", bv_a, mdl_bv());
      chk("B busy_vec", bv_b, mdl_bv());
   endtask

   // Advance one clock and apply the register-file rules to the reference.
   task automatic tick();
      @(posedge CLK);
      if (RST) begin
         for (int r = 0; r < 32; r++) begin
            mdl_regs[r] = '0;
            mdl_busy[r] = 1'b0;
         end
      end else begin
         if (WEN && wsel != 0) begin
            mdl_regs[wsel] = wdat;
            mdl_busy[wsel] = 1'b0;
         end
         if (RSV && rsv_sel != 0) mdl_busy[rsv_sel] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      RST = 0; WEN = 0; RSV = 0; wsel = '0; rsv_sel = '0; wdat = '0;
   endtask

   typedef struct {
      logic        rst, wen, rsv;
      regidx_t     wsel, rsv_sel, rs0, rs1;
      word_t       wdat;
      word_t       e_rd0, e_rd1;
      logic        e_rb0, e_rb1;
      logic [31:0] e_bv;
   } vec_t;

   vec_t tbl [16];

   initial begin
      // rst wen rsv wsel rsv_sel rs0 rs1 wdat e_rd0 e_rd1 e_rb0 e_rb1 e_bv
      tbl[0]  = '{0, 1, 0, 5, 0, 0, 5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0};
      tbl[1]  = '{0, 0, 0, 0, 0, 5, 5, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0};
      tbl[2]  = '{0, 1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        0, 0, 32'h0};
      tbl[3]  = '{0, 0, 1, 0, 7, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0};
      tbl[4]  = '{0, 0, 0, 0, 0, 7, 5, 32'h0,        32'h0,        32'hDEADBEEF, 1, 0, 32'h80};
      tbl[5]  = '{0, 1, 0, 7, 0, 7, 7, 32'h12,       32'h12,       32'h12,       0, 0, 32'h80};
      tbl[6]  = '{0, 0, 0, 0, 0, 7, 0, 32'h0,        32'h12,       32'h0,        0, 0, 32'h0};
      tbl[7]  = '{0, 0, 1, 0, 9, 9, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0};
      tbl[8]  = '{0, 1, 1, 9, 9, 9, 0, 32'h55,       32'h55,       32'h0,        0, 0, 32'h200};
      tbl[9]  = '{0, 0, 1, 0, 9, 9, 9, 32'h0,        32'h55,       32'h55,       1, 1, 32'h200};
      tbl[10] = '{0, 0, 0, 0, 0, 9, 0, 32'h0,        32'h55,       32'h0,        1, 0, 32'h200};
      tbl[11] = '{0, 1, 0, 9, 0, 9, 9, 32'h66,       32'h66,       32'h66,       0, 0, 32'h200};
      tbl[12] = '{0, 0, 0, 0, 0, 9, 7, 32'h0,        32'h66,       32'h12,       0, 0, 32'h0};
      tbl[13] = '{0, 0, 1, 0, 3, 3, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0};
      tbl[14] = '{1, 1, 0, 3, 0, 3, 5, 32'hAA,       32'hAA,       32'hDEADBEEF, 0, 0, 32'h8};
      tbl[15] = '{0, 0, 0, 0, 0, 3, 5, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0};

      idle();
      rsel_a = '0;
      rsel_b = '0;
      RST = 1;
      tick();
      tick();
      RST = 0;

      for (int r = 0; r < 32; r++) begin
         rsel_a = {2{5'(r)}};
         rsel_b = {4{5'(r)}};
         #1;
         chk($sformatf("reset A rdat0 r%0d", r), rdat_a[31:0], 32'h0);
         chk($sformatf("reset A rdat1 r%0d", r), rdat_a[63:32], 32'h0);
         check_model();
      end
      chk("reset busy_vec", bv_a, 32'h0);

      for (int k = 0; k < 16; k++) begin
         RST = tbl[k].rst; WEN = tbl[k].wen; RSV = tbl[k].rsv;
         wsel = tbl[k].wsel; rsv_sel = tbl[k].rsv_sel; wdat = tbl[k].wdat;
         rsel_a = {tbl[k].rs1, tbl[k].rs0};
         rsel_b = {tbl[k].rs1, tbl[k].rs0, tbl[k].rs1, tbl[k].rs0};
         #1;
         chk($sformatf("v%0d rdat0", k), rdat_a[31:0], tbl[k].e_rd0);
         chk($sformatf("v%0d rdat1", k), rdat_a[63:32], tbl[k].e_rd1);
         chk($sformatf("v%0d rd_busy0", k), 32'(rb_a[0]), 32'(tbl[k].e_rb0));
         chk($sformatf("v%0d rd_busy1", k), 32'(rb_a[1]), 32'(tbl[k].e_rb1));
         chk($sformatf("v%0d busy_vec", k), bv_a, tbl[k].e_bv);
         check_model();
         tick();
      end

      // Without forwarding, a same-cycle read of the written register sees the old value.
      idle();
      WEN = 1; wsel = 5'd20; wdat = 32'hCAFE0001;
      rsel_b = {4{5'd20}};
      rsel_a = {2{5'd20}};
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("nobyp rdat%0d", i), rdat_b[i*32 +: 32], 32'h0);
      check_model();
      tick();
      idle();
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("nobyp next rdat%0d", i), rdat_b[i*32 +: 32], 32'hCAFE0001);
      check_model();

      for (int n = 0; n < 600; n++) begin
         RST = ($urandom_range(0, 59) == 0);
         WEN = $urandom_range(0, 1);
         RSV = ($urandom_range(0, 2) == 0);
         wsel = regidx_t'($urandom_range(0, 7));
         rsv_sel = regidx_t'($urandom_range(0, 7));
         wdat = $urandom;
         rsel_a = 10'($urandom);
         rsel_b = 20'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            rsel_a[4:0] = wsel;
            rsel_b[9:5] = wsel;
         end
         #1;
         check_model();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameters SHALL be: DW, 32, data width; NREG, 32, register count (power of 2, >=2); NRD, 2, read ports (1..4); BYPASS, 1, 1 = write-to-read forwarding enabled.
REQ-002 Derived constant AW = $clog2(NREG) SHALL size all selects.
REQ-003 Ports SHALL be, one per line below (clock and reset first):
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 RST  in  1  synchronous active-high reset, sampled on rising CLK.
REQ-006 WEN  in  1  write enable.
REQ-007 wsel  in  AW  write register index.
REQ-008 wdat  in  DW  write data.
REQ-009 rsel  in  NRD*AW  packed read indices, port i at [i*AW +: AW].
REQ-010 rdat  out  NRD*DW  packed read data, port i at [i*DW +: DW].
REQ-011 RSV  in  1  reserve request: marks rsv_sel pending a future write.
REQ-012 rsv_sel  in  AW  register index to reserve.
REQ-013 rd_busy  out  NRD  per-port hazard flag: operand not yet valid.
REQ-014 busy_vec  out  NREG  current scoreboard, bit r = register r pending.

Function
REQ-015 Register 0 SHALL read 0 always; writes and reservations to index 0 SHALL be ignored; busy_vec[0] SHALL be 0.
REQ-016 Write: WEN=1, wsel!=0 SHALL update the entry at the next rising edge.
REQ-017 Reads SHALL be combinational; rdat[i] = entry[rsel[i]] when BYPASS=0.
REQ-018 BYPASS=1: when WEN=1 and wsel==rsel[i]!=0, rdat[i] SHALL equal wdat in the same cycle.
REQ-019 Scoreboard: RSV=1, rsv_sel!=0 SHALL set busy[rsv_sel] at the next edge.
REQ-020 WEN=1, wsel!=0 SHALL clear busy[wsel] at the next edge.
REQ-021 Simultaneous RSV and WEN to same index: busy SHALL end 1 (new reservation wins); data SHALL still be written.
REQ-022 RSV to an already-busy register SHALL leave it busy (no counting); one later write clears it.
REQ-023 WEN to a non-busy register SHALL write data, busy unchanged (0).
REQ-024 rd_busy[i] = busy[rsel[i]], except 0 when BYPASS=1 and WEN=1 and wsel==rsel[i]; rd_busy[i]=0 for rsel[i]==0.
REQ-025 All read ports SHALL be independent; any ports MAY select the same index.
REQ-026 Outputs SHALL have no latency beyond stated: reads/rd_busy combinational, state visible one cycle after the edge.

Reset
REQ-027 RST=1 at a rising edge SHALL clear all entries to 0 and busy_vec to 0, overriding WEN and RSV in that cycle.
REQ-028 While RST asserted, rdat SHALL reflect cleared state after the first edge; bypass SHALL still apply combinationally.
REQ-029 Reset mid-reservation SHALL discard all pending busy bits; no write is replayed.

Structure
REQ-030 DW default, NREG default, and a regidx_t typedef SHALL live in cpu_types_pkg; word_t SHALL be reused for data.
REQ-031 Scoreboard bit-vector logic SHALL be one sub-module, reg_scoreboard (ports CLK, RST, set/clr enables and indices, busy_vec).
REQ-032 Storage SHALL be flops (no RAM inference), sized NREG x DW, entry 0 may be omitted.

Verification
REQ-033 Reset then read all 32 regs on both ports -> rdat=0, busy_vec=0.
REQ-034 WEN, wsel=5, wdat=0xDEADBEEF; next cycle rsel0=5 -> rdat0=0xDEADBEEF; BYPASS=1 same-cycle rsel1=5 -> rdat1=0xDEADBEEF, BYPASS=0 -> old value 0.
REQ-035 Write wsel=0 wdat=0xFFFFFFFF, RSV rsv_sel=0 -> rdat=0, busy_vec[0]=0.
REQ-036 RSV rsv_sel=7; next cycle rsel0=7 -> rd_busy0=1; WEN wsel=7 wdat=0x12 same cycle -> rd_busy0=0 (BYPASS=1), busy_vec[7]=0 next cycle.
REQ-037 Same cycle RSV rsv_sel=9 and WEN wsel=9 wdat=0x55 on busy reg 9 -> busy_vec[9]=1, entry 9=0x55.
REQ-038 RSV rsv_sel=3 then RST=1 for one cycle -> busy_vec=0, entry 3=0; NRD=4 build repeats REQ-034 on all ports.
